seven_seg_display_controller: RTL and testbench

Time-multiplexed controller for a common-anode N-digit seven-segment display. It shares one internal seven_seg_hex_decoder instance across all digits. It scans digits round-robin with a per-slot blanking interval to prevent ghosting. Display data is loaded through a valid/ready handshake and committed only at frame boundaries, so a frame never shows a mix of old and new data. It sits between any value-producing logic and the board display pins.

---
 rtl/seven_seg_display_controller.sv | 200 ++++++++++++++++++++
 tb/tb_seven_seg_display_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display_controller.sv
// ---------------------------------------------------------------------------
// seven_seg_display_controller
//
// Time-multiplexed driver for a common-anode N-digit seven-segment display.
// Digits are scanned round-robin, one slot of REFRESH_DIV cycles each.
// The first BLANK_CYCLES cycles of every slot keep all anodes off so the
// previous digit's pattern cannot ghost onto the next anode. One hex
// decoder is shared by all digits.
//
// New display data is accepted into a one-deep pending buffer. The buffer
// is copied into the display register only when the digit index wraps back
// to 0, so one frame never mixes old and new data.
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN - when defined, digit i (i > 0) is blanked when
//   nibbles i..N_DIGITS-1 of the display register are all zero. Its
//   decimal point is forced off as well.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   value_in     4*N_DIGITS hex nibbles, nibble i drives digit i
//   value_valid  value_in is offered
//   value_ready  pending buffer is empty, so value_in can be accepted
//   digit_en     per-digit enable, sampled live (0 keeps that anode off)
//   dp_in        per-digit decimal point, active-high, sampled live
//   an           anode enables, active-low, registered
//   seg          segments {A,B,C,D,E,F,G}, active-low, registered
//   dp           decimal point, active-low, registered
//   frame_start  one-cycle pulse when the digit index wraps to 0
//
// Handshake (valid/ready): a transfer happens on a rising clk edge where
// value_valid && value_ready are both high. value_in is captured at that
// edge. While value_ready is low, value_valid is ignored and the source
// must hold value_in stable until the transfer.
// ---------------------------------------------------------------------------
module seven_seg_display_controller #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   display;
  logic [4*N_DIGITS-1:0]   pending;
  logic                    pend_full;

  phase_t                  phase;
  logic                    slot_wrap;
  logic                    frame_wrap;
  logic                    take;
  logic [N_DIGITS-1:0]     eff_en;
  logic [3:0]              cur_nib;
  logic [6:0]              dec_segs;
  logic [N_DIGITS-1:0]     an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  assign value_ready = ~pend_full;
  assign take        = value_valid & value_ready;
  assign slot_wrap   = (cnt == CNT_MAX);
  assign frame_wrap  = slot_wrap & (idx == IDX_MAX);
  assign cur_nib     = display[idx*4 +: 4];

  seven_seg_hex_decoder u_dec (
    .hex  (cur_nib),
    .segs (dec_segs)
  );

  // The phase is a pure function of the slot counter. With BLANK_CYCLES = 0
  // the compare is never true and every slot is DRIVE.
  always_comb begin
    phase = PH_DRIVE;
    if (cnt < BLANK_C) phase = PH_BLANK;
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit downward. A digit stays suppressed
  // until a non-zero nibble has been seen at or above it. Digit 0 is never
  // touched, so a value of zero still shows a single "0".
  logic nz;
  always_comb begin
    nz     = 1'b0;
    eff_en = digit_en;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      nz = nz | (display[4*i +: 4] != 4'h0);
      if (!nz) eff_en[i] = 1'b0;
    end
  end
`else
  always_comb begin
    eff_en = digit_en;
  end
`endif

  always_comb begin
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (phase == PH_DRIVE && eff_en[idx]) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = ~dec_segs;
      dp_nxt      = ~dp_in[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      display     <= '0;
      pending     <= '0;
      pend_full   <= 1'b0;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt <= slot_wrap ? '0 : cnt + 1'b1;
      if (slot_wrap) idx <= frame_wrap ? '0 : idx + 1'b1;
      frame_start <= frame_wrap;

      // Capture needs an empty buffer and commit needs a full one, so the
      // two branches can never both want to fire on the same edge.
      if (take) begin
        pending   <= value_in;
        pend_full <= 1'b1;
      end else if (frame_wrap && pend_full) begin
        display   <= pending;
        pend_full <= 1'b0;
      end

      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// seven_seg_hex_decoder
//
// Hex nibble to seven-segment pattern. The output is active-high, with bit
// order {A,B,C,D,E,F,G}. Letters b and d are lowercase so they cannot be
// confused with 8 and 0.
//
// Ports:
//   hex   4-bit value
//   segs  segment pattern, 1 = segment lit
// ---------------------------------------------------------------------------
module seven_seg_hex_decoder (
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  always_comb begin
    segs = 7'h00;
    case (hex)
      4'h0: segs = 7'b1111110;
      4'h1: segs = 7'b0110000;
      4'h2: segs = 7'b1101101;
      4'h3: segs = 7'b1111001;
      4'h4: segs = 7'b0110011;
      4'h5: segs = 7'b1011011;
      4'h6: segs = 7'b1011111;
      4'h7: segs = 7'b1110000;
      4'h8: segs = 7'b1111111;
      4'h9: segs = 7'b1111011;
      4'hA: segs = 7'b1110111;
      4'hB: segs = 7'b0011111;
      4'hC: segs = 7'b1001110;
      4'hD: segs = 7'b0111101;
      4'hE: segs = 7'b1001111;
      4'hF: segs = 7'b1000111;
      default: segs = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_seven_seg_display_controller.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_display_controller
//
// Directed bench for seven_seg_display_controller with N_DIGITS=4,
// REFRESH_DIV=8 and BLANK_CYCLES=2. Accepted values go into an expected
// queue. The queue head becomes the shown value at each predicted frame
// boundary. Every cycle, the pins are compared against a reference
// computed from the shown value, the live inputs and the bench's own edge
// count. Explicit constant checks cover the key display patterns.
// ---------------------------------------------------------------------------
module tb_seven_seg_display_controller;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = N * RD;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] value_in = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  seven_seg_display_controller #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .digit_en    (digit_en),
    .dp_in       (dp_in),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  int          edges  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] shown = '0;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Active-low {A..G} patterns of the hex digits.
  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] r;
    case (h)
      4'h0: r = 7'b0000001;
      4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;
      4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;
      4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;
      4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;
      4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;
      default: r = 7'b0111000;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model at the edge, sample #1 later, compare.
  task automatic cyc();
    logic        commit;
    logic        xfer;
    logic [15:0] vin;
    logic [3:0]  en;
    logic [3:0]  dpi;
    logic [15:0] disp;
    logic [3:0]  en_eff;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int          s;
    int          c;
    int          d;
    commit = (((edges + 1) % FR) == 0) && (exp_q.size() != 0);
    xfer   = value_valid && (exp_q.size() == 0);
    vin    = value_in;
    en     = digit_en;
    dpi    = dp_in;
    disp   = shown;
    @(posedge clk);
    edges++;
    if (xfer)   exp_q.push_back(vin);
    if (commit) shown = exp_q.pop_front();
    #1;
    s = edges - 1;
    c = s % RD;
    d = (s / RD) % N;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (c >= BC) begin
      en_eff = en;
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 1; i < N; i++)
        if ((disp >> (4 * i)) == 16'h0) en_eff[i] = 1'b0;
`endif
      if (en_eff[d]) begin
        e_an[d] = 1'b0;
        e_seg   = seg_of(disp[4*d +: 4]);
        e_dp    = ~dpi[d];
      end
    end
    chk("an", {12'h0, an}, {12'h0, e_an});
    chk("seg", {9'h0, seg}, {9'h0, e_seg});
    chk("dp", {15'h0, dp}, {15'h0, e_dp});
    chk("frame_start", {15'h0, frame_start}, {15'h0, 1'((edges % FR) == 0)});
    chk("value_ready", {15'h0, value_ready}, {15'h0, 1'(exp_q.size() == 0)});
  endtask

  task automatic run_to(input int k);
    while (edges < k) cyc();
  endtask

  logic bad;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_seg", {9'h0, seg}, 16'h007F);
    chk("rst_dp", {15'h0, dp}, 16'h0001);
    chk("rst_frame_start", {15'h0, frame_start}, 16'h0000);
    chk("rst_ready", {15'h0, value_ready}, 16'h0001);
    rst_n = 1'b1;

    // scan start: two blank cycles, then digit 0 showing "0"
    run_to(2);
    chk("s1_an_blank", {12'h0, an}, 16'h000F);
    chk("s1_seg_blank", {9'h0, seg}, 16'h007F);
    run_to(3);
    chk("s1_an_d0", {12'h0, an}, 16'h000E);
    chk("s1_seg_d0", {9'h0, seg}, {9'h0, 7'b0000001});
    run_to(9);
    chk("s1_an_d1_blank", {12'h0, an}, 16'h000F);

    // load 1A3F mid-frame; the current frame keeps showing 0000
    value_in = 16'h1A3F;
    value_valid = 1'b1;
    cyc();
    value_valid = 1'b0;
    chk("s2_ready_low", {15'h0, value_ready}, 16'h0000);
    run_to(27);
    chk("s2_old_d3", {9'h0, seg}, {9'h0, 7'b0000001});

    // offer 2222 while busy and hold it
    value_in = 16'h2222;
    value_valid = 1'b1;
    run_to(32);
    chk("s2_frame_start", {15'h0, frame_start}, 16'h0001);
    chk("s2_ready_back", {15'h0, value_ready}, 16'h0001);
    cyc();
    value_valid = 1'b0;
    chk("s3_ready_low", {15'h0, value_ready}, 16'h0000);
    run_to(35);
    chk("s2_d0_an", {12'h0, an}, 16'h000E);
    chk("s2_d0_F", {9'h0, seg}, {9'h0, 7'b0111000});
    run_to(59);
    chk("s2_d3_an", {12'h0, an}, 16'h0007);
    chk("s2_d3_1", {9'h0, seg}, {9'h0, 7'b1001111});
    run_to(67);
    chk("s3_d0_2", {9'h0, seg}, {9'h0, 7'b0010010});

    // digits 1 and 3 disabled for a whole frame, decimal point on digit 2
    run_to(64 + 3);
    digit_en = 4'b0101;
    dp_in = 4'b0100;
    run_to(96);
    digit_en = 4'b0101;
    bad = 1'b0;
    for (int i = 0; i < FR; i++) begin
      cyc();
      if (!an[1] || !an[3]) bad = 1'b1;
    end
    chk("s4_an13_off", {15'h0, bad}, 16'h0000);
    digit_en = 4'hF;
    dp_in = 4'h0;

    // fill the buffer, then reset in the middle of a DRIVE phase
    value_in = 16'h7777;
    value_valid = 1'b1;
    cyc();
    value_valid = 1'b0;
    run_to(133);
    chk("s5_pre_an", {12'h0, an}, 16'h000E);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s5_an", {12'h0, an}, 16'h000F);
    chk("s5_seg", {9'h0, seg}, 16'h007F);
    chk("s5_dp", {15'h0, dp}, 16'h0001);
    chk("s5_ready", {15'h0, value_ready}, 16'h0001);
    exp_q.delete();
    shown = '0;
    edges = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_to(3);
    chk("s5_restart_an", {12'h0, an}, 16'h000E);
    chk("s5_restart_seg", {9'h0, seg}, {9'h0, 7'b0000001});

    // 0042, then 0000
    value_in = 16'h0042;
    value_valid = 1'b1;
    cyc();
    value_valid = 1'b0;
    run_to(35);
    chk("s6_d0_2", {9'h0, seg}, {9'h0, 7'b0010010});
    run_to(43);
    chk("s6_d1_an", {12'h0, an}, 16'h000D);
    chk("s6_d1_4", {9'h0, seg}, {9'h0, 7'b1001100});
    run_to(51);
`ifdef LEADING_ZERO_BLANK_EN
    chk("s6_d2_an", {12'h0, an}, 16'h000F);
    chk("s6_d2_seg", {9'h0, seg}, 16'h007F);
`else
    chk("s6_d2_an", {12'h0, an}, 16'h000B);
    chk("s6_d2_seg", {9'h0, seg}, {9'h0, 7'b0000001});
`endif
    value_in = 16'h0000;
    value_valid = 1'b1;
    cyc();
    value_valid = 1'b0;
    run_to(67);
    chk("s6_zero_d0_an", {12'h0, an}, 16'h000E);
    chk("s6_zero_d0_seg", {9'h0, seg}, {9'h0, 7'b0000001});
    run_to(75);
`ifdef LEADING_ZERO_BLANK_EN
    chk("s6_zero_d1_an", {12'h0, an}, 16'h000F);
`else
    chk("s6_zero_d1_an", {12'h0, an}, 16'h000D);
`endif
    run_to(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
